// File: rtl/mux_scan_sequencer_pkg.sv
// Shared constants and types for the 4:1 mux scan sequencer.
// Channel k is driven onto the mux select as {s0,s1} = CH_SEL_MAP[k].
package mux_scan_sequencer_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DWELL  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Fixed lab wiring: i0..i3 sit on select codes 00..11.
  localparam logic [NUM_CH-1:0][SEL_W-1:0] CH_SEL_MAP = {2'd3, 2'd2, 2'd1, 2'd0};
endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Control/status and mux-side bundle between the scan sequencer and its user.
// master = fixture side (start, mask, mux output), slave = sequencer side.
interface mux_scan_sequencer_if;
  import mux_scan_sequencer_pkg::*;

  logic              start;
  logic [NUM_CH-1:0] ch_mask;
  logic              y;
  logic              s0;
  logic              s1;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] sample;

  modport master (output start, ch_mask, y, input s0, s1, busy, done, sample);
  modport slave  (input start, ch_mask, y, output s0, s1, busy, done, sample);
endinterface

// File: rtl/mux_scan_sequencer_next_ch_find.sv
// Finds the next enabled channel: lowest set bit when first=1,
// otherwise the lowest set bit strictly above cur.
module next_ch_find
  import mux_scan_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              first,
  output logic [SEL_W-1:0]  nxt,
  output logic              vld
);
  // Walking downwards lets the lowest qualifying channel win.
  always_comb begin
    nxt = '0;
    vld = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask[k] && (first || (k > int'(cur)))) begin
        nxt = SEL_W'(k);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the 4:1 mux select over the enabled channels, dwelling DWELL cycles
// on each, and publishes the captured bits as one snapshot with a done pulse.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_scan_sequencer_if.slave  bus
);
  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] work_q, work_d;
  logic [NUM_CH-1:0] sample_q, sample_d;
  logic [SEL_W-1:0]  nxt_ch;
  logic              nxt_vld;
  logic              idle;

  assign idle = (state_q == ST_IDLE);

  // In IDLE search the live mask from the bottom; mid-scan use the latched copy.
  next_ch_find u_find (
    .mask  (idle ? bus.ch_mask : mask_q),
    .cur   (ch_q),
    .first (idle),
    .nxt   (nxt_ch),
    .vld   (nxt_vld)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    work_d   = work_q;
    sample_d = sample_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (nxt_vld) begin
            mask_d  = bus.ch_mask;
            ch_d    = nxt_ch;
            cnt_d   = RELOAD;
            work_d  = '0;
            state_d = ST_DWELL;
          end else begin
            sample_d = '0;
            state_d  = ST_FINISH;
          end
        end
      end
      ST_DWELL: begin
        if (cnt_q == '0) begin
          work_d[ch_q] = bus.y;
          if (nxt_vld) begin
            ch_d  = nxt_ch;
            cnt_d = RELOAD;
          end else begin
            sample_d = work_d;
            state_d  = ST_FINISH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      work_q   <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      work_q   <= work_d;
      sample_q <= sample_d;
    end
  end

  assign {bus.s0, bus.s1} = (state_q == ST_DWELL) ? CH_SEL_MAP[ch_q] : '0;
  assign bus.busy   = (state_q == ST_DWELL);
  assign bus.done   = (state_q == ST_FINISH);
  assign bus.sample = sample_q;
endmodule
